// File: rtl/tx_framer.sv
// tx_framer: frames upstream FIFO bytes onto a byte-wide transmit interface.
// A frame goes out as a run of 0x55 preamble bytes, one 0xD5 start byte,
// the payload, and then an enforced idle gap. The frame is aborted into a
// flush when the FIFO underruns or the link drops. Both counters wrap
// modulo 2^16.
module tx_framer #(
  parameter int P_PREAMBLE_LEN = 7,
  parameter int P_IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_sync,
  input  logic [8:0]  fifo_data_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic [7:0]  tx_data,
  output logic        tx_ctrl,
  output logic        busy_o,
  output logic [15:0] tx_frames_o,
  output logic [15:0] drop_frames_o
);

  localparam int CNT_W = 16;

  localparam logic [7:0] C_PREAMBLE = 8'h55;
  localparam logic [7:0] C_SFD      = 8'hD5;
  localparam logic [7:0] C_IDLE     = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [7:0]         tx_data_r;
  logic [7:0]         tx_data_s;
  logic               tx_ctrl_r;
  logic               tx_ctrl_s;
  logic [15:0]        tx_frames_r;
  logic [15:0]        drop_frames_r;
  logic               fifo_rd_s;
  logic               frame_done_s;
  logic               frame_drop_s;
  logic [7:0]         fifo_byte_s;
  logic               fifo_last_s;

  assign fifo_byte_s = fifo_data_i[8:1];
  assign fifo_last_s = fifo_data_i[0];

  // Next-state, next-output and pop decode. The transmit byte for cycle N+1
  // is chosen in cycle N, so each state drives what the wire shows next.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    tx_data_s    = C_IDLE;
    tx_ctrl_s    = 1'b0;
    fifo_rd_s    = 1'b0;
    frame_done_s = 1'b0;
    frame_drop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_i) begin
          if (link_sync) begin
            // The first preamble byte leaves on the edge that sees the start.
            state_s   = (P_PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_SFD;
            cnt_s     = '0;
            tx_ctrl_s = 1'b1;
            tx_data_s = C_PREAMBLE;
          end else begin
            // No peer: the queued frame can never be sent, discard it.
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!link_sync) begin
          state_s = ST_FLUSH;
        end else begin
          tx_ctrl_s = 1'b1;
          tx_data_s = C_PREAMBLE;
          // One preamble byte was already issued from IDLE.
          if (cnt_r == CNT_W'(P_PREAMBLE_LEN - 2)) begin
            state_s = ST_SFD;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end
      end
      ST_SFD: begin
        if (!link_sync) begin
          state_s = ST_FLUSH;
        end else begin
          tx_ctrl_s = 1'b1;
          tx_data_s = C_SFD;
          state_s   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (link_sync && !fifo_empty_i) begin
          fifo_rd_s = 1'b1;
          tx_ctrl_s = 1'b1;
          tx_data_s = fifo_byte_s;
          if (fifo_last_s) begin
            frame_done_s = 1'b1;
            state_s      = ST_IFG;
            cnt_s        = '0;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          // Underrun or link loss: abort and drain the rest of the frame.
          state_s = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!fifo_empty_i) begin
          fifo_rd_s = 1'b1;
          if (fifo_last_s) begin
            frame_drop_s = 1'b1;
            state_s      = ST_IFG;
            cnt_s        = '0;
          end else begin
            state_s = ST_FLUSH;
          end
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_IFG: begin
        if (cnt_r == CNT_W'(P_IFG_CYCLES - 1)) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counters and registered transmit outputs; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      tx_data_r     <= C_IDLE;
      tx_ctrl_r     <= 1'b0;
      tx_frames_r   <= 16'h0000;
      drop_frames_r <= 16'h0000;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      tx_data_r <= tx_data_s;
      tx_ctrl_r <= tx_ctrl_s;
      if (frame_done_s) begin
        tx_frames_r <= tx_frames_r + 16'd1;
      end
      if (frame_drop_s) begin
        drop_frames_r <= drop_frames_r + 16'd1;
      end
    end
  end

  // The pop strobe must never fire while reset is held.
  assign fifo_rd_o     = fifo_rd_s & ~reset;
  assign tx_data       = tx_data_r;
  assign tx_ctrl       = tx_ctrl_r;
  assign busy_o        = (state_r != ST_IDLE);
  assign tx_frames_o   = tx_frames_r;
  assign drop_frames_o = drop_frames_r;

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: a queue-based FIFO model feeds random frames, and the
// expected wire stream is built per frame from the framing rules.
module tb_tx_framer;

  localparam int PRE_LEN = 7;
  localparam int IFG_LEN = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        link_sync;
  logic [8:0]  fifo_data_i;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic [7:0]  tx_data;
  logic        tx_ctrl;
  logic        busy_o;
  logic [15:0] tx_frames_o;
  logic [15:0] drop_frames_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] fq[$];
  logic [8:0] held[$];
  logic [9:0] exp_q[$];
  logic [7:0] cb[$];

  logic        obs_rd;
  logic        obs_ctrl;
  logic        obs_busy;
  logic [7:0]  obs_data;
  logic [15:0] obs_frames;
  logic [15:0] obs_drops;
  logic [8:0]  junk;
  bit          saw_ctrl;
  int          nfr;

  tx_framer dut (
    .clk           (clk),
    .reset         (reset),
    .link_sync     (link_sync),
    .fifo_data_i   (fifo_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_o     (fifo_rd_o),
    .tx_data       (tx_data),
    .tx_ctrl       (tx_ctrl),
    .busy_o        (busy_o),
    .tx_frames_o   (tx_frames_o),
    .drop_frames_o (drop_frames_o)
  );

  always #5 clk = ~clk;

  // Single comparison point: count it and report any mismatch.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() == 0) ? 9'h000 : fq[0];
  endtask

  // One clock: present the FIFO head, sample at the falling edge, pop after the rising edge.
  task automatic step();
    drive_fifo();
    @(negedge clk);
    obs_rd     = fifo_rd_o;
    obs_ctrl   = tx_ctrl;
    obs_data   = tx_data;
    obs_busy   = busy_o;
    obs_frames = tx_frames_o;
    obs_drops  = drop_frames_o;
    @(posedge clk);
    #1;
    if (obs_rd && fq.size() > 0) junk = fq.pop_front();
    drive_fifo();
  endtask

  task automatic gen_frame(input int len, input bit ramp);
    logic [7:0] b;
    cb.delete();
    for (int k = 0; k < len; k++) begin
      b = ramp ? 8'(k) : 8'($urandom_range(0, 255));
      cb.push_back(b);
      fq.push_back({b, (k == len - 1)});
    end
  endtask

  // Expected {rd, ctrl, data} per cycle for a frame sent in full:
  // preamble, SFD (first pop), payload (pop of the next byte), idle gap.
  task automatic expect_frame();
    int len = cb.size();
    for (int j = 0; j < PRE_LEN; j++) exp_q.push_back({1'b0, 1'b1, 8'h55});
    exp_q.push_back({1'b1, 1'b1, 8'hD5});
    for (int k = 0; k < len; k++) exp_q.push_back({(k < len - 1), 1'b1, cb[k]});
    for (int j = 0; j < IFG_LEN; j++) exp_q.push_back(10'h000);
  endtask

  task automatic run_stream(input string tag, input int limit);
    logic [9:0] e;
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      e = exp_q.pop_front();
      step();
      check_eq(tag, {obs_rd, obs_ctrl, obs_data}, e);
      n++;
    end
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while (fq.size() > 0 && n < budget) begin
      step();
      if (obs_ctrl) saw_ctrl = 1'b1;
      n++;
    end
    check_eq({tag, "_drained"}, fq.size(), 0);
  endtask

  task automatic idle_steps(input int n);
    repeat (n) begin
      step();
      if (obs_ctrl) saw_ctrl = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fq.delete();
    exp_q.delete();
    repeat (2) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    link_sync = 1'b1;
    fq.delete();
    drive_fifo();

    // Reset state with a frame waiting and the link up.
    gen_frame(4, 1'b0);
    repeat (3) step();
    check_eq("rst_ctrl", obs_ctrl, 0);
    check_eq("rst_data", obs_data, 0);
    check_eq("rst_busy", obs_busy, 0);
    check_eq("rst_rd", obs_rd, 0);
    check_eq("rst_frames", obs_frames, 0);
    check_eq("rst_drops", obs_drops, 0);

    // Nominal 64-byte ramp frame.
    do_reset();
    exp_q.push_back(10'h000);
    gen_frame(64, 1'b1);
    expect_frame();
    reset = 1'b0;
    run_stream("nominal", 1000);
    check_eq("nominal_frames", obs_frames, 1);
    check_eq("nominal_drops", obs_drops, 0);
    check_eq("nominal_busy", obs_busy, 0);

    // Back-to-back random frames, the first one a single byte.
    do_reset();
    exp_q.push_back(10'h000);
    nfr = $urandom_range(2, 4);
    for (int f = 0; f < nfr; f++) begin
      gen_frame((f == 0) ? 1 : $urandom_range(2, 24), 1'b0);
      expect_frame();
    end
    reset = 1'b0;
    run_stream("b2b", 1000);
    check_eq("b2b_frames", obs_frames, nfr);

    // Underrun after byte 10; the other 54 bytes arrive later and are flushed.
    do_reset();
    gen_frame(64, 1'b0);
    held.delete();
    while (fq.size() > 10) held.push_front(fq.pop_back());
    exp_q.push_back(10'h000);
    for (int j = 0; j < PRE_LEN; j++) exp_q.push_back({1'b0, 1'b1, 8'h55});
    exp_q.push_back({1'b1, 1'b1, 8'hD5});
    for (int k = 0; k < 10; k++) exp_q.push_back({(k < 9), 1'b1, cb[k]});
    for (int j = 0; j < 4; j++) exp_q.push_back(10'h000);
    reset = 1'b0;
    run_stream("underrun", 1000);
    saw_ctrl = 1'b0;
    while (held.size() > 0) fq.push_back(held.pop_front());
    wait_drained("underrun", 500);
    idle_steps(IFG_LEN + 2);
    check_eq("underrun_ctrl_quiet", saw_ctrl, 0);
    check_eq("underrun_drops", obs_drops, 1);
    check_eq("underrun_frames", obs_frames, 0);
    check_eq("underrun_busy", obs_busy, 0);

    // Link drops in the third preamble cycle.
    do_reset();
    gen_frame($urandom_range(3, 30), 1'b0);
    exp_q.push_back(10'h000);
    exp_q.push_back({1'b0, 1'b1, 8'h55});
    exp_q.push_back({1'b0, 1'b1, 8'h55});
    reset = 1'b0;
    run_stream("linkloss_pre", 10);
    link_sync = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 8'h55});
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    run_stream("linkloss_cut", 10);
    saw_ctrl = 1'b0;
    wait_drained("linkloss", 500);
    idle_steps(IFG_LEN + 2);
    check_eq("linkloss_ctrl_quiet", saw_ctrl, 0);
    check_eq("linkloss_drops", obs_drops, 1);
    check_eq("linkloss_frames", obs_frames, 0);

    // Link down in IDLE with three frames queued.
    do_reset();
    link_sync = 1'b0;
    for (int f = 0; f < 3; f++) gen_frame($urandom_range(1, 20), 1'b0);
    reset = 1'b0;
    saw_ctrl = 1'b0;
    wait_drained("linkdown", 2000);
    idle_steps(IFG_LEN + 2);
    check_eq("linkdown_ctrl_quiet", saw_ctrl, 0);
    check_eq("linkdown_drops", obs_drops, 3);
    check_eq("linkdown_frames", obs_frames, 0);

    // Reset while the second frame is in DATA.
    link_sync = 1'b1;
    do_reset();
    exp_q.push_back(10'h000);
    gen_frame(3, 1'b0);
    expect_frame();
    gen_frame(40, 1'b0);
    expect_frame();
    reset = 1'b0;
    run_stream("middata_pre", 1 + (PRE_LEN + 1 + 3 + IFG_LEN) + PRE_LEN + 1 + 10);
    check_eq("middata_frames_before", obs_frames, 1);
    check_eq("middata_busy_before", obs_busy, 1);
    reset = 1'b1;
    step();
    check_eq("middata_rd_in_reset", obs_rd, 0);
    check_eq("middata_ctrl_before_edge", obs_ctrl, 1);
    step();
    check_eq("middata_ctrl", obs_ctrl, 0);
    check_eq("middata_data", obs_data, 0);
    check_eq("middata_rd", obs_rd, 0);
    check_eq("middata_frames", obs_frames, 0);
    check_eq("middata_drops", obs_drops, 0);
    check_eq("middata_busy", obs_busy, 0);

    // Counters preset just below the wrap point; one-byte frame, then one dropped frame.
    do_reset();
    exp_q.push_back(10'h000);
    gen_frame(1, 1'b0);
    expect_frame();
    force dut.tx_frames_r   = 16'hFFFF;
    force dut.drop_frames_r = 16'hFFFF;
    reset = 1'b0;
    run_stream("wrap_start", 1);
    release dut.tx_frames_r;
    release dut.drop_frames_r;
    run_stream("one_byte", 1000);
    check_eq("wrap_frames", obs_frames, 16'h0000);
    check_eq("wrap_drops_held", obs_drops, 16'hFFFF);
    link_sync = 1'b0;
    gen_frame(1, 1'b0);
    saw_ctrl = 1'b0;
    wait_drained("wrap_drop", 200);
    idle_steps(IFG_LEN + 2);
    check_eq("wrap_drops", obs_drops, 16'h0000);
    check_eq("wrap_drop_ctrl_quiet", saw_ctrl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
